am_demod: RTL and testbench

AM envelope demodulator sitting directly downstream of the two CIC decimators (I and Q channels) in the AM SDR receive chain. It takes each decimated I/Q pair, computes its magnitude with an iterative (one micro-rotation per clock) CORDIC in vectoring mode, and removes the carrier DC with a leaky-integrator high-pass. It then applies a power-of-two audio gain with saturation and presents one signed 16-bit audio sample per input pair.

---
 rtl/am_demod.sv | 162 ++++++++++++++++
 tb/tb_am_demod.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/am_demod.sv
// AM envelope demodulator: CORDIC-vectoring magnitude of each I/Q pair, leaky
// DC tracker high-pass, power-of-two audio gain with saturation.
// Ports:
//   CLK, RSTb         clock, asynchronous active-low reset
//   in_tick           one-cycle strobe, i_in/q_in valid
//   i_in, q_in        signed I/Q samples (BITS)
//   gain              audio left shift 0..7, used in the OUT state
//   audio_out         signed audio sample, registered (BITS)
//   out_tick          one-cycle strobe, audio_out valid
//   busy              high while a sample is in flight
//   overrun           one-cycle pulse when an in_tick was dropped
module am_demod #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned ITER     = 12,
    parameter int unsigned DC_SHIFT = 8
) (
    input  logic            CLK,
    input  logic            RSTb,
    input  logic            in_tick,
    input  logic [BITS-1:0] i_in,
    input  logic [BITS-1:0] q_in,
    input  logic [2:0]      gain,
    output logic [BITS-1:0] audio_out,
    output logic            out_tick,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned XW     = BITS + 3;
    localparam int unsigned MAG_W  = BITS + 1;
    localparam int unsigned AC_W   = BITS + 2;
    localparam int unsigned DACC_W = AC_W + DC_SHIFT;
    localparam int unsigned SH_W   = AC_W + 7;
    localparam int unsigned KW     = 4;

    typedef enum logic [1:0] {IDLE, ROT, SCALE, OUT} state_t;

    state_t                    state, state_nxt;
    logic signed [XW-1:0]      x, x_nxt, y, y_nxt;
    logic        [KW-1:0]      k, k_nxt;
    logic        [MAG_W-1:0]   mag, mag_nxt;
    logic signed [DACC_W-1:0]  dc_acc, dc_acc_nxt;
    logic        [BITS-1:0]    audio_nxt;
    logic                      out_tick_nxt, busy_nxt, overrun_nxt;

    logic signed [XW-1:0]      i_ext, q_ext, x_shr, y_shr;
    logic signed [AC_W-1:0]    ac;
    logic signed [SH_W-1:0]    sh;
    logic        [BITS-1:0]    sat;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            mag       <= '0;
            dc_acc    <= '0;
            audio_out <= '0;
            out_tick  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            k         <= k_nxt;
            mag       <= mag_nxt;
            dc_acc    <= dc_acc_nxt;
            audio_out <= audio_nxt;
            out_tick  <= out_tick_nxt;
            busy      <= busy_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_nxt    = state;
        x_nxt        = x;
        y_nxt        = y;
        k_nxt        = k;
        mag_nxt      = mag;
        dc_acc_nxt   = dc_acc;
        audio_nxt    = audio_out;
        out_tick_nxt = 1'b0;
        busy_nxt     = busy;
        overrun_nxt  = 1'b0;

        i_ext = XW'($signed(i_in));
        q_ext = XW'($signed(q_in));
        x_shr = x >>> k;
        y_shr = y >>> k;

        // High-passed sample: magnitude minus tracked DC
        ac = {1'b0, mag} - AC_W'(dc_acc >>> DC_SHIFT);
        sh = {{(SH_W-AC_W){ac[AC_W-1]}}, ac} << gain;

        // Clip to the signed BITS range when the shifted value no longer fits
        if (sh[SH_W-1:BITS-1] == '0 || sh[SH_W-1:BITS-1] == '1) begin
            sat = sh[BITS-1:0];
        end else if (sh[SH_W-1]) begin
            sat = {1'b1, {(BITS-1){1'b0}}};
        end else begin
            sat = {1'b0, {(BITS-1){1'b1}}};
        end

        // A strobe arriving while a sample is in flight is dropped
        if (in_tick && state != IDLE) begin
            overrun_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (in_tick) begin
                    // Pre-rotate into the right half-plane so CORDIC converges
                    if (i_in[BITS-1]) begin
                        x_nxt = -i_ext;
                        y_nxt = -q_ext;
                    end else begin
                        x_nxt = i_ext;
                        y_nxt = q_ext;
                    end
                    k_nxt     = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ROT;
                end
            end
            ROT: begin
                // Rotate towards y=0; both updates use the pre-rotation values
                if (!y[XW-1]) begin
                    x_nxt = x + y_shr;
                    y_nxt = y - x_shr;
                end else begin
                    x_nxt = x - y_shr;
                    y_nxt = y + x_shr;
                end
                k_nxt = k + KW'(1);
                if (k == KW'(ITER - 1)) begin
                    state_nxt = SCALE;
                end
            end
            SCALE: begin
                // Undo CORDIC gain (~0.60742) with truncated shift terms
                mag_nxt   = MAG_W'((x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9));
                state_nxt = OUT;
            end
            OUT: begin
                dc_acc_nxt   = dc_acc + {{DC_SHIFT{ac[AC_W-1]}}, ac};
                audio_nxt    = sat;
                out_tick_nxt = 1'b1;
                busy_nxt     = 1'b0;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_am_demod.sv
// Directed self-checking bench for am_demod (BITS=16, ITER=12, DC_SHIFT=8).
module tb_am_demod;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_tick;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic        [2:0]  gain;
    logic signed [15:0] audio_out;
    logic               out_tick;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int passed = 0;

    am_demod #(.BITS(16), .ITER(12), .DC_SHIFT(8)) dut (
        .CLK      (clk),
        .RSTb     (rst_n),
        .in_tick  (in_tick),
        .i_in     (i_in),
        .q_in     (q_in),
        .gain     (gain),
        .audio_out(audio_out),
        .out_tick (out_tick),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Stimulus: one strobe, then wait (bounded) for out_tick; lat counts edges after E0
    task automatic run_sample(input logic signed [15:0] i, input logic signed [15:0] q,
                              output logic signed [15:0] aud, output int lat,
                              output logic busy_mid);
        @(negedge clk);
        i_in    = i;
        q_in    = q;
        in_tick = 1'b1;
        @(negedge clk);
        in_tick  = 1'b0;
        busy_mid = busy;
        lat      = 0;
        while (out_tick !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        aud = audio_out;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        int seen = 0;
        rst_n   = 1'b1;
        in_tick = 1'b0;
        i_in    = '0;
        q_in    = '0;
        gain    = 3'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (audio_out !== 16'sd0) $display("FAIL reset_audio: got %0d want 0", audio_out); else passed++;
        checks++; if (out_tick !== 1'b0) $display("FAIL reset_out_tick: got %b want 0", out_tick); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (out_tick !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL idle_no_out_tick: got %0d ticks want 0", seen); else passed++;
    endtask

    task automatic test_first_sample;
        logic signed [15:0] aud;
        int lat, d;
        logic bm;
        gain = 3'd0;
        run_sample(16'sd16384, 16'sd0, aud, lat, bm);
        checks++; if (lat !== 14) $display("FAIL first_latency: got %0d want 14", lat); else passed++;
        checks++; if (bm !== 1'b1) $display("FAIL busy_in_flight: got %b want 1", bm); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL busy_at_out_tick: got %b want 0", busy); else passed++;
        d = int'(aud) - 16384;
        checks++; if ((d <= 20 && d >= -20) !== 1'b1) $display("FAIL first_audio: got %0d want 16384+-20", aud); else passed++;
        @(negedge clk);
        checks++; if (out_tick !== 1'b0) $display("FAIL out_tick_width: got %b want 0", out_tick); else passed++;
        // mag 15000 minus dc (16384>>>8 = 64)
        run_sample(-16'sd12000, -16'sd9000, aud, lat, bm);
        d = int'(aud) - 14936;
        checks++; if ((d <= 16 && d >= -16) !== 1'b1) $display("FAIL second_audio: got %0d want 14936+-16", aud); else passed++;
    endtask

    task automatic test_overrun;
        int t, lat;
        int ov_early = 0;
        @(negedge clk);
        i_in    = 16'sd3000;
        q_in    = 16'sd0;
        in_tick = 1'b1;
        @(negedge clk);
        in_tick = 1'b0;
        t = 0;
        repeat (4) begin
            @(negedge clk);
            t++;
            if (overrun !== 1'b0) ov_early++;
        end
        checks++; if (ov_early !== 0) $display("FAIL overrun_spurious: got %0d want 0", ov_early); else passed++;
        in_tick = 1'b1;
        @(negedge clk);
        t++;
        in_tick = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", overrun); else passed++;
        @(negedge clk);
        t++;
        checks++; if (overrun !== 1'b0) $display("FAIL overrun_width: got %b want 0", overrun); else passed++;
        while (out_tick !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++; if (t !== 14) $display("FAIL overrun_first_latency: got %0d want 14", t); else passed++;
        // New strobe during the out_tick cycle must be accepted
        in_tick = 1'b1;
        @(negedge clk);
        in_tick = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL coincident_accept: got busy %b want 1", busy); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL coincident_overrun: got %b want 0", overrun); else passed++;
        lat = 0;
        while (out_tick !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 14) $display("FAIL coincident_latency: got %0d want 14", lat); else passed++;
    endtask

    task automatic test_reset_mid;
        logic signed [15:0] aud;
        int lat, d;
        logic bm;
        int seen = 0;
        @(negedge clk);
        i_in    = 16'sd16384;
        q_in    = 16'sd0;
        in_tick = 1'b1;
        @(negedge clk);
        in_tick = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
        checks++; if (audio_out !== 16'sd0) $display("FAIL midreset_audio: got %0d want 0", audio_out); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_tick !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL midreset_no_tick: got %0d ticks want 0", seen); else passed++;
        gain = 3'd0;
        run_sample(16'sd16384, 16'sd0, aud, lat, bm);
        checks++; if (lat !== 14) $display("FAIL postreset_latency: got %0d want 14", lat); else passed++;
        d = int'(aud) - 16384;
        checks++; if ((d <= 20 && d >= -20) !== 1'b1) $display("FAIL postreset_audio: got %0d want 16384+-20", aud); else passed++;
    endtask

    task automatic test_dc_removal;
        logic signed [15:0] aud;
        logic signed [15:0] first = '0;
        int lat, d;
        logic bm;
        int timeouts = 0;
        int late_max = 0;
        int min_aud = 0;
        do_reset();
        gain = 3'd0;
        for (int n = 0; n < 2200; n++) begin
            run_sample(16'sd10000, 16'sd10000, aud, lat, bm);
            if (lat != 14) timeouts++;
            if (n == 0) first = aud;
            if (int'(aud) < min_aud) min_aud = int'(aud);
            if (n >= 2048) begin
                if (int'(aud) > late_max) late_max = int'(aud);
                if (-int'(aud) > late_max) late_max = -int'(aud);
            end
        end
        checks++; if (timeouts !== 0) $display("FAIL dc_latency: got %0d late samples want 0", timeouts); else passed++;
        d = int'(first) - 14142;
        checks++; if ((d <= 20 && d >= -20) !== 1'b1) $display("FAIL dc_first: got %0d want 14142+-20", first); else passed++;
        checks++; if ((late_max < 16) !== 1'b1) $display("FAIL dc_settled: got |audio| %0d want <16", late_max); else passed++;
        checks++; if ((min_aud >= -16) !== 1'b1) $display("FAIL dc_undershoot: got %0d want >=-16", min_aud); else passed++;
    endtask

    task automatic test_gain_sat;
        logic signed [15:0] aud;
        int lat, d;
        logic bm;
        int nonzero = 0;
        // Unsaturated gain: mag ~1000, shifted by 3
        do_reset();
        gain = 3'd3;
        run_sample(16'sd1000, 16'sd0, aud, lat, bm);
        d = int'(aud) - 8000;
        checks++; if ((d <= 24 && d >= -24) !== 1'b1) $display("FAIL gain3_audio: got %0d want 8000+-24", aud); else passed++;
        // gain=7 step up and back down from a settled level
        do_reset();
        gain = 3'd7;
        repeat (4) begin
            run_sample(16'sd0, 16'sd0, aud, lat, bm);
            if (aud !== 16'sd0) nonzero++;
        end
        checks++; if (nonzero !== 0) $display("FAIL zero_input: got %0d nonzero want 0", nonzero); else passed++;
        run_sample(16'sh8000, 16'sh8000, aud, lat, bm);
        checks++; if (aud !== 16'sh7fff) $display("FAIL sat_pos_gain7: got %0d want 32767", aud); else passed++;
        repeat (300) run_sample(16'sh8000, 16'sh8000, aud, lat, bm);
        run_sample(16'sd0, 16'sd0, aud, lat, bm);
        checks++; if (aud !== 16'sh8000) $display("FAIL sat_neg_gain7: got %0d want -32768", aud); else passed++;
        // gain=0: +-46341 swings exceed the 16-bit range
        do_reset();
        gain = 3'd0;
        run_sample(16'sh8000, 16'sh8000, aud, lat, bm);
        checks++; if (aud !== 16'sh7fff) $display("FAIL sat_pos_gain0: got %0d want 32767", aud); else passed++;
        repeat (500) run_sample(16'sh8000, 16'sh8000, aud, lat, bm);
        run_sample(16'sd0, 16'sd0, aud, lat, bm);
        checks++; if (aud !== 16'sh8000) $display("FAIL sat_neg_gain0: got %0d want -32768", aud); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_overrun();
        test_reset_mid();
        test_dc_removal();
        test_gain_sat();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
